// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
package pipe_stage_reg_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_W         = 32;
    localparam int unsigned EXC_W        = 5;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned TNEW_W_DEF   = 4;
    localparam int unsigned DATA_W_DEF   = 128;

    localparam logic [EXC_W-1:0] EXC_NONE     = 5'd0;
    localparam logic [PC_W-1:0]  FLUSH_PC_DEF = 32'h0000_3000;

    // Payload field offsets inside data_i, shared so every stage packs identically
    localparam int unsigned PL_FIELD_W  = 32;
    localparam int unsigned PL_PC4_LSB  = 0;
    localparam int unsigned PL_ALU_LSB  = 32;
    localparam int unsigned PL_MD_LSB   = 64;
    localparam int unsigned PL_MEM_LSB  = 96;

    // Default payload layout; mem carries load data or CP0 read data
    typedef struct packed {
        logic [PL_FIELD_W-1:0] mem;
        logic [PL_FIELD_W-1:0] md;
        logic [PL_FIELD_W-1:0] alu;
        logic [PL_FIELD_W-1:0] pc4;
    } payload_t;

    // Action selected for the stage on a given edge, highest priority first
    typedef enum logic [2:0] {
        ACT_RESET = 3'd0,
        ACT_REQ   = 3'd1,
        ACT_FLUSH = 3'd2,
        ACT_HOLD  = 3'd3,
        ACT_LOAD  = 3'd4
    } stage_act_e;

    function automatic payload_t pack_payload(
        input logic [PL_FIELD_W-1:0] pc4,
        input logic [PL_FIELD_W-1:0] alu,
        input logic [PL_FIELD_W-1:0] md,
        input logic [PL_FIELD_W-1:0] mem
    );
        payload_t p;
        p.pc4 = pc4;
        p.alu = alu;
        p.md  = md;
        p.mem = mem;
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream-in / downstream-out signal bundle of one pipeline stage register.
// master drives the _i side and observes _o; slave is the register itself.
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TNEW_W = TNEW_W_DEF
) ();

    logic                valid_i;
    logic [INSTR_W-1:0]  instr_i;
    logic [PC_W-1:0]     pc_i;
    logic                bd_i;
    logic [EXC_W-1:0]    exc_i;
    logic [TNEW_W-1:0]   tnew_i;
    logic [DATA_W-1:0]   data_i;

    logic                valid_o;
    logic [INSTR_W-1:0]  instr_o;
    logic [PC_W-1:0]     pc_o;
    logic                bd_o;
    logic [EXC_W-1:0]    exc_o;
    logic [TNEW_W-1:0]   tnew_o;
    logic [DATA_W-1:0]   data_o;

    modport master (
        output valid_i, instr_i, pc_i, bd_i, exc_i, tnew_i, data_i,
        input  valid_o, instr_o, pc_o, bd_o, exc_o, tnew_o, data_o
    );

    modport slave (
        input  valid_i, instr_i, pc_i, bd_i, exc_i, tnew_i, data_i,
        output valid_o, instr_o, pc_o, bd_o, exc_o, tnew_o, data_o
    );

endinterface

// File: rtl/pipe_stage_reg_stat_ctr.sv
// 32-bit event counter with enable and synchronous active-low clear; wraps at 2^32.
module pipe_stat_ctr
    import pipe_stage_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with hold, bubble, exception flush and Tnew countdown.
// Define PIPE_STAGE_STATS_EN to add stall/bubble event counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned    DATA_W   = DATA_W_DEF,
    parameter int unsigned    TNEW_W   = TNEW_W_DEF,
    parameter int unsigned    TNEW_DEC = 1,
    parameter logic [PC_W-1:0] FLUSH_PC = FLUSH_PC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic stall,
    input  logic flush,
    pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

    localparam logic [TNEW_W-1:0] DEC = TNEW_W'(TNEW_DEC);

    stage_act_e act_c;

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q,    pc_d;
    logic               bd_q,    bd_d;
    logic [EXC_W-1:0]   exc_q,   exc_d;
    logic [TNEW_W-1:0]  tnew_q,  tnew_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [TNEW_W-1:0]  tnew_load_c;

    // Resolve the control inputs into a single action by priority
    always_comb begin
        act_c = ACT_LOAD;
        if (!reset) begin
            act_c = ACT_RESET;
        end else if (req) begin
            act_c = ACT_REQ;
        end else if (flush) begin
            act_c = ACT_FLUSH;
        end else if (stall) begin
            act_c = ACT_HOLD;
        end
    end

    // Saturating countdown; a bubble never advertises a pending producer
    always_comb begin
        tnew_load_c = '0;
        if (bus.valid_i && (bus.tnew_i > DEC)) begin
            tnew_load_c = bus.tnew_i - DEC;
        end
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        tnew_d  = tnew_q;
        data_d  = data_q;
        unique case (act_c)
            ACT_RESET, ACT_REQ: begin
                valid_d = 1'b0;
                instr_d = '0;
                pc_d    = FLUSH_PC;
                bd_d    = 1'b0;
                exc_d   = EXC_NONE;
                tnew_d  = '0;
                data_d  = '0;
            end
            // Bubble keeps pc/bd so CP0 still sees the right EPC and BD
            ACT_FLUSH: begin
                valid_d = 1'b0;
                instr_d = '0;
                pc_d    = bus.pc_i;
                bd_d    = bus.bd_i;
                exc_d   = EXC_NONE;
                tnew_d  = '0;
                data_d  = '0;
            end
            ACT_HOLD: begin
            end
            ACT_LOAD: begin
                valid_d = bus.valid_i;
                instr_d = bus.instr_i;
                pc_d    = bus.pc_i;
                bd_d    = bus.bd_i;
                exc_d   = bus.exc_i;
                tnew_d  = tnew_load_c;
                data_d  = bus.data_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= FLUSH_PC;
            bd_q    <= 1'b0;
            exc_q   <= EXC_NONE;
            tnew_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            tnew_q  <= tnew_d;
            data_q  <= data_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.instr_o = instr_q;
    assign bus.pc_o    = pc_q;
    assign bus.bd_o    = bd_q;
    assign bus.exc_o   = exc_q;
    assign bus.tnew_o  = tnew_q;
    assign bus.data_o  = data_q;

`ifdef PIPE_STAGE_STATS_EN
    logic stall_ev_c;
    logic bubble_ev_c;

    assign stall_ev_c  = (act_c == ACT_HOLD);
    assign bubble_ev_c = (act_c == ACT_REQ) || (act_c == ACT_FLUSH);

    pipe_stat_ctr u_stall_ctr (
        .clk   (clk),
        .reset (reset),
        .en_i  (stall_ev_c),
        .cnt_o (stall_cnt_o)
    );

    pipe_stat_ctr u_bubble_ctr (
        .clk   (clk),
        .reset (reset),
        .en_i  (bubble_ev_c),
        .cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench for pipe_stage_reg (TNEW_DEC=1 and TNEW_DEC=0 instances).
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    typedef struct packed {
        logic         valid;
        logic [31:0]  instr;
        logic [31:0]  pc;
        logic         bd;
        logic [4:0]   exc;
        logic [3:0]   tnew;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_n, req, stall, flush;
    logic v_valid, v_bd;
    logic [31:0] v_instr, v_pc;
    logic [4:0] v_exc;
    logic [3:0] v_tnew;
    logic [127:0] v_data;

    int total = 0;
    int bad = 0;
    exp_t e1, e0, got;
    int m_stall = 0;
    int m_bub = 0;

    pipe_stage_reg_if #(.DATA_W(128), .TNEW_W(4)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(128), .TNEW_W(4)) bus0 ();

    assign bus1.valid_i = v_valid;
    assign bus1.instr_i = v_instr;
    assign bus1.pc_i    = v_pc;
    assign bus1.bd_i    = v_bd;
    assign bus1.exc_i   = v_exc;
    assign bus1.tnew_i  = v_tnew;
    assign bus1.data_i  = v_data;
    assign bus0.valid_i = v_valid;
    assign bus0.instr_i = v_instr;
    assign bus0.pc_i    = v_pc;
    assign bus0.bd_i    = v_bd;
    assign bus0.exc_i   = v_exc;
    assign bus0.tnew_i  = v_tnew;
    assign bus0.data_i  = v_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] sc1, bc1, sc0, bc0;
`endif

    pipe_stage_reg #(.DATA_W(128), .TNEW_W(4), .TNEW_DEC(1)) dut1 (
        .clk   (clk),
        .reset (r_n),
        .req   (req),
        .stall (stall),
        .flush (flush),
        .bus   (bus1)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt_o  (sc1),
        .bubble_cnt_o (bc1)
`endif
    );

    pipe_stage_reg #(.DATA_W(128), .TNEW_W(4), .TNEW_DEC(0)) dut0 (
        .clk   (clk),
        .reset (r_n),
        .req   (req),
        .stall (stall),
        .flush (flush),
        .bus   (bus0)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt_o  (sc0),
        .bubble_cnt_o (bc0)
`endif
    );

    function automatic exp_t out1();
        return {bus1.valid_o, bus1.instr_o, bus1.pc_o, bus1.bd_o, bus1.exc_o, bus1.tnew_o, bus1.data_o};
    endfunction

    function automatic exp_t out0();
        return {bus0.valid_o, bus0.instr_o, bus0.pc_o, bus0.bd_o, bus0.exc_o, bus0.tnew_o, bus0.data_o};
    endfunction

    // Reference: what the stage must hold after the coming edge, from the priority rules
    function automatic exp_t model_next(exp_t cur, int dec);
        exp_t n;
        int t;
        n = cur;
        if (!r_n || req) begin
            n = '0;
            n.pc = 32'h0000_3000;
        end else if (flush) begin
            n = '0;
            n.pc = v_pc;
            n.bd = v_bd;
        end else if (!stall) begin
            t = int'(v_tnew) - dec;
            if (t < 0 || !v_valid) t = 0;
            n.valid = v_valid;
            n.instr = v_instr;
            n.pc    = v_pc;
            n.bd    = v_bd;
            n.exc   = v_exc;
            n.tnew  = 4'(t);
            n.data  = v_data;
        end
        return n;
    endfunction

    task automatic tick();
        e1 = model_next(e1, 1);
        e0 = model_next(e0, 0);
        if (!r_n) begin
            m_stall = 0;
            m_bub = 0;
        end else if (req || flush) begin
            m_bub++;
        end else if (stall) begin
            m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        v_valid = 1'($urandom);
        v_instr = $urandom;
        v_pc    = $urandom;
        v_bd    = 1'($urandom);
        v_exc   = 5'($urandom);
        v_tnew  = 4'($urandom);
        v_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        rand_inputs();
        r_n = 1'b0; req = 1'($urandom); stall = 1'b1; flush = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            got = out1();
            total++;
            if (got !== e1) begin
                bad++;
                $display("FAIL reset_vec%0d got=%h exp=%h", i, got, e1);
            end
            total++;
            if ({bus1.valid_o, bus1.pc_o, bus1.tnew_o, bus1.data_o} !== {1'b0, 32'h3000, 4'd0, 128'd0}) begin
                bad++;
                $display("FAIL reset_const%0d got valid=%0b pc=%h tnew=%0d data=%h", i,
                         bus1.valid_o, bus1.pc_o, bus1.tnew_o, bus1.data_o);
            end
        end
        r_n = 1'b1; req = 1'b0; stall = 1'b0; flush = 1'b0;
        v_valid = 1'b1; v_instr = 32'h3c01_1234; v_pc = 32'h3004; v_tnew = 4'd3;
        tick();
        total++;
        if ({bus1.instr_o, bus1.pc_o, bus1.tnew_o} !== {32'h3c01_1234, 32'h3004, 4'd2}) begin
            bad++;
            $display("FAIL first_load got instr=%h pc=%h tnew=%0d exp 3c011234 3004 2",
                     bus1.instr_o, bus1.pc_o, bus1.tnew_o);
        end
    endtask

    task automatic test_tnew_sat();
        logic [3:0] tin [3];
        logic [3:0] tout [3];
        tin[0] = 4'd2; tin[1] = 4'd1; tin[2] = 4'd0;
        tout[0] = 4'd1; tout[1] = 4'd0; tout[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            v_valid = 1'b1;
            v_tnew = tin[i];
            tick();
            total++;
            if (bus1.tnew_o !== tout[i]) begin
                bad++;
                $display("FAIL tnew_sat%0d got=%0d exp=%0d", i, bus1.tnew_o, tout[i]);
            end
        end
        v_tnew = 4'd3;
        tick();
        total++;
        if (bus0.tnew_o !== 4'd3) begin
            bad++;
            $display("FAIL tnew_dec0 got=%0d exp=3", bus0.tnew_o);
        end
        got = out1();
        total++;
        if (got !== e1) begin
            bad++;
            $display("FAIL tnew_vec got=%h exp=%h", got, e1);
        end
    endtask

    task automatic test_stall_flush();
        rand_inputs();
        v_valid = 1'b1; v_pc = 32'h3010; v_tnew = 4'd5;
        tick();
        total++;
        if (bus1.pc_o !== 32'h3010) begin
            bad++;
            $display("FAIL stall_preload got pc=%h exp=3010", bus1.pc_o);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
            got = out1();
            total++;
            if (got !== e1 || bus1.pc_o !== 32'h3010 || bus1.tnew_o !== 4'd4) begin
                bad++;
                $display("FAIL stall_hold%0d got=%h exp=%h", i, got, e1);
            end
        end
        flush = 1'b1;
        rand_inputs();
        v_pc = 32'h3014; v_bd = 1'b1;
        tick();
        total++;
        if ({bus1.valid_o, bus1.instr_o, bus1.pc_o, bus1.bd_o, bus1.tnew_o} !==
            {1'b0, 32'd0, 32'h3014, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL flush_over_stall got v=%0b instr=%h pc=%h bd=%0b tnew=%0d",
                     bus1.valid_o, bus1.instr_o, bus1.pc_o, bus1.bd_o, bus1.tnew_o);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_req();
        rand_inputs();
        v_valid = 1'b1; v_bd = 1'b1; v_exc = 5'd4;
        tick();
        req = 1'b1; stall = 1'b1; flush = 1'b1;
        v_pc = 32'h3020;
        tick();
        total++;
        if ({bus1.pc_o, bus1.bd_o, bus1.exc_o, bus1.valid_o} !== {32'h3000, 1'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL req_priority got pc=%h bd=%0b exc=%0d v=%0b",
                     bus1.pc_o, bus1.bd_o, bus1.exc_o, bus1.valid_o);
        end
        req = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_invalid();
        rand_inputs();
        v_valid = 1'b0; v_tnew = 4'd3;
        tick();
        total++;
        if ({bus1.tnew_o, bus1.valid_o, bus0.tnew_o, bus0.valid_o} !== {4'd0, 1'b0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL invalid_in got tnew1=%0d v1=%0b tnew0=%0d v0=%0b",
                     bus1.tnew_o, bus1.valid_o, bus0.tnew_o, bus0.valid_o);
        end
        total++;
        if (bus1.data_o !== v_data || bus1.pc_o !== v_pc) begin
            bad++;
            $display("FAIL invalid_copy got data=%h pc=%h exp data=%h pc=%h",
                     bus1.data_o, bus1.pc_o, v_data, v_pc);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            r_n   = ($urandom_range(0, 31) != 0);
            req   = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            tick();
            total++;
            if (out1() !== e1 || out0() !== e0) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random%0d got1=%h exp1=%h got0=%h exp0=%h", i, out1(), e1, out0(), e0);
                end
            end
        end
        r_n = 1'b1; req = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        r_n = 1'b0;
        tick();
        r_n = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            tick();
        end
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        flush = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        total++;
        if (sc1 !== 32'd5 || bc1 !== 32'd3 || sc1 !== 32'(m_stall) || bc1 !== 32'(m_bub)) begin
            bad++;
            $display("FAIL stats_count got stall=%0d bubble=%0d exp 5 3", sc1, bc1);
        end
        stall = 1'b1;
        r_n = 1'b0;
        tick();
        total++;
        if (sc1 !== 32'd0 || bc1 !== 32'd0 || sc0 !== 32'd0 || bc0 !== 32'd0) begin
            bad++;
            $display("FAIL stats_clear got stall=%0d bubble=%0d", sc1, bc1);
        end
        r_n = 1'b1; stall = 1'b0;
    endtask
`endif

    initial begin
        r_n = 1'b0; req = 1'b0; stall = 1'b0; flush = 1'b0;
        e1 = '0; e0 = '0;
        rand_inputs();
        test_reset();
        test_tnew_sat();
        test_stall_flush();
        test_req();
        test_invalid();
        test_random();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the generic successor of the fixed M→W latch.
- One instance sits at each boundary: F/D, D/E, E/M and M/W.
- Carries instr, pc, bd/exc tags, a configurable payload bus and the Tnew countdown.
- Adds hold (stall), bubble insertion (flush), exception flush (Req), a valid bit, and a configurable Tnew decrement.

Parameters:
- DATA_W, 128: width of concatenated payload bus (pc4, ALU out, MD out, load data, CP0 out, ...).
- TNEW_W, 4: width of Tnew field.
- TNEW_DEC, 1: amount subtracted from Tnew on each load; 0 for stages where Tnew is computed fresh.
- FLUSH_PC, 32'h0000_3000: pc value loaded on reset and on Req.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-low.
- req  in  1  exception/eret request; flushes stage to FLUSH_PC bubble.
- stall  in  1  hold current contents.
- flush  in  1  insert bubble, keeping pc/bd for EPC.
- valid_i  in  1  upstream slot holds a real instruction.
- instr_i  in  32  instruction.
- pc_i  in  32  instruction address.
- bd_i  in  1  branch-delay-slot flag.
- exc_i  in  5  pending ExcCode, 0 = none.
- tnew_i  in  TNEW_W  producer Tnew.
- data_i  in  DATA_W  payload.
- valid_o, instr_o, pc_o, bd_o, exc_o, tnew_o, data_o  out  matching widths  registered copies.

Behaviour:
- All outputs come straight from flops; latency is 1 cycle, with no combinational input→output path.
- Priority per rising edge (highest first): reset==0 > req > flush > stall > load.
- Reset (reset==0):
  - valid_o=0, instr_o=0, pc_o=FLUSH_PC, bd_o=0, exc_o=0, tnew_o=0, data_o=0.
  - Reset asserted mid-stall or mid-flush still wins and clears everything.
- req=1: same values as reset. stall and flush are ignored.
- flush=1 (req=0):
  - valid_o=0, instr_o=0, exc_o=0, tnew_o=0, data_o=0.
  - pc_o=pc_i, bd_o=bd_i, so a bubble behind a stall reports the correct EPC/BD to CP0.
  - flush overrides a simultaneous stall.
- stall=1 (req=0, flush=0): every output register holds. Tnew does not count down while held.
- Load (all control low):
  - valid_o=valid_i; instr, pc, bd, exc and data are copied.
  - tnew_o = (tnew_i > TNEW_DEC) ? tnew_i - TNEW_DEC : 0, in unsigned TNEW_W arithmetic (saturates at 0, never wraps).
- Invalid input (valid_i=0) loads normally. tnew_o is forced to 0 so a bubble never blocks forwarding.
- No internal FSM beyond the register set; the optional counters below are the only extra state.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, add outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0]:
  - stall_cnt_o increments on each edge where the stall branch is taken.
  - bubble_cnt_o increments on each edge where the flush or req branch is taken.
  - Both wrap at 2^32 and clear on reset==0.
- When not defined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package: EXC_NONE=5'd0, FLUSH_PC default, the TNEW_W default, and a payload field-offset localparam set so each stage packs and unpacks data_i consistently.
- One natural sub-module: pipe_stat_ctr (32-bit enable/clear counter), instanced twice under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs → valid_o=0, pc_o=0x3000, tnew_o=0, data_o=0; then release and load instr 0x3c011234, pc 0x3004, tnew 3 → next cycle instr_o=0x3c011234, pc_o=0x3004, tnew_o=2.
- Tnew saturation: TNEW_DEC=1, tnew_i sequence 2,1,0 → tnew_o 1,0,0; with TNEW_DEC=0 and tnew_i=3 → tnew_o=3.
- Stall vs flush: load pc 0x3010; assert stall 3 cycles with changing inputs → outputs frozen at pc 0x3010; assert stall+flush with pc_i=0x3014, bd_i=1 → valid_o=0, instr_o=0, pc_o=0x3014, bd_o=1, tnew_o=0.
- Req priority: assert req with stall=1, flush=1, pc_i=0x3020 → pc_o=0x3000, bd_o=0, exc_o=0, valid_o=0.
- Invalid input: valid_i=0, tnew_i=3 → tnew_o=0, valid_o=0.
- Stats (macro on): 5 stall cycles, 2 flush cycles, 1 req → stall_cnt_o=5, bubble_cnt_o=3; reset=0 → both 0.
